wb_pwm_fader: RTL and testbench



---
 rtl/wb_pwm_fader_pkg.sv | 34 +++
 rtl/wb_pwm_fader_channel.sv | 57 +++++
 rtl/wb_pwm_fader.sv | 167 ++++++++++++++++
 tb/tb_wb_pwm_fader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pwm_fader_pkg.sv
// Shared register map, field positions and bus FSM encoding for the
// Wishbone PWM fader.
package wb_pwm_pkg;

   localparam logic [3:0] ADDR_CTRL     = 4'd0;
   localparam logic [3:0] ADDR_PRESCALE = 4'd1;
   localparam logic [3:0] ADDR_FADEDIV  = 4'd2;
   localparam logic [3:0] ADDR_STATUS   = 4'd3;
   localparam logic [3:0] ADDR_CH0      = 4'd4;

   localparam int unsigned CTRL_ENABLE_BIT = 0;
   localparam int unsigned CTRL_INVERT_BIT = 1;

   localparam int unsigned FADE_EN_BIT = 16;
   localparam int unsigned LIVE_LSB    = 24;

   typedef enum logic {
      BUS_IDLE,
      BUS_ACK
   } bus_state_t;

   // Byte-lane merge of a write into an existing 32-bit register image.
   function automatic logic [31:0] sel_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
      logic [31:0] r;
      r = old_val;
      for (int unsigned b = 0; b < 4; b++) begin
         if (sel[b]) r[8*b +: 8] = new_val[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/wb_pwm_fader_channel.sv
// One PWM channel: target/live duty, fade ramp counter, compare and busy flag.
// Live duty only changes at period boundaries so the output never glitches.
module pwm_fade_channel
   import wb_pwm_pkg::*;
#(
   parameter int unsigned PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr,
   input  logic [PWM_BITS-1:0] wr_target,
   input  logic                wr_fade_en,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   input  logic                period_end,
   input  logic [7:0]          fadediv,
   output logic [PWM_BITS-1:0] target,
   output logic                fade_en,
   output logic [PWM_BITS-1:0] live,
   output logic                busy,
   output logic                cmp
);

   logic [7:0] fade_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         target   <= '0;
         fade_en  <= 1'b0;
         live     <= '0;
         fade_cnt <= '0;
      end else begin
         if (wr) begin
            target  <= wr_target;
            fade_en <= wr_fade_en;
         end
         // Uses the pre-write target when a write lands on the period end.
         if (period_end) begin
            if (!fade_en) begin
               live     <= target;
               fade_cnt <= '0;
            end else if (fade_cnt == fadediv) begin
               fade_cnt <= '0;
               if (live < target)      live <= live + 1'b1;
               else if (live > target) live <= live - 1'b1;
            end else begin
               fade_cnt <= fade_cnt + 1'b1;
            end
         end
      end
   end

   always_comb begin
      busy = fade_en && (live != target);
      cmp  = pwm_cnt < live;
   end

endmodule

// File: rtl/wb_pwm_fader.sv
// Wishbone slave with NCH PWM channels sharing one prescaler and period
// counter; each channel can fade its live duty toward a programmed target.
module wb_pwm_fader
   import wb_pwm_pkg::*;
#(
   parameter int unsigned AW       = 30,
   parameter int unsigned DW       = 32,
   parameter int unsigned NCH      = 4,
   parameter int unsigned PWM_BITS = 8,
   parameter int unsigned PRE_BITS = 16
) (
   input  logic            wb_clk_i,
   input  logic            wb_reset_i,
   input  logic [AW-1:0]   wb_adr_i,
   input  logic [DW-1:0]   wb_dat_i,
   output logic [DW-1:0]   wb_dat_o,
   input  logic            wb_we_i,
   input  logic [DW/8-1:0] wb_sel_i,
   input  logic            wb_cyc_i,
   input  logic            wb_stb_i,
   output logic            wb_ack_o,
   output logic [NCH-1:0]  pwm_o
);

   localparam int unsigned LIVE_W = (PWM_BITS > 8) ? 8 : PWM_BITS;

   bus_state_t state, next_state;
   logic [3:0] adr;
   logic       req, wr;
   logic       adr_unused;
   logic [31:0] rdata;

   logic                enable, invert;
   logic [PRE_BITS-1:0] prescale, pre_cnt;
   logic [7:0]          fadediv;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                tick, period_end;

   logic [NCH-1:0] busy, cmp, raw;
   logic [31:0]    ch_word [NCH];

   assign adr        = wb_adr_i[3:0];
   assign adr_unused = &{1'b0, wb_adr_i[AW-1:4]};

   // Bus FSM: state register, next state, outputs.
   always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
      if (wb_reset_i) state <= BUS_IDLE;
      else            state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         BUS_IDLE: if (wb_cyc_i && wb_stb_i) next_state = BUS_ACK;
         BUS_ACK:  next_state = BUS_IDLE;
         default:  next_state = BUS_IDLE;
      endcase
   end

   always_comb begin
      wb_ack_o = (state == BUS_ACK);
      req      = (state == BUS_IDLE) && wb_cyc_i && wb_stb_i;
      wr       = req && wb_we_i;
   end

   always_comb begin
      rdata = '0;
      case (adr)
         ADDR_CTRL: begin
            rdata[CTRL_ENABLE_BIT] = enable;
            rdata[CTRL_INVERT_BIT] = invert;
         end
         ADDR_PRESCALE: rdata[PRE_BITS-1:0] = prescale;
         ADDR_FADEDIV:  rdata[7:0]          = fadediv;
         ADDR_STATUS:   rdata[NCH-1:0]      = busy;
         default: begin
            for (int unsigned n = 0; n < NCH; n++) begin
               if (adr == ADDR_CH0 + 4'(n)) rdata = ch_word[n];
            end
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
      if (wb_reset_i) begin
         wb_dat_o <= '0;
         enable   <= 1'b0;
         invert   <= 1'b0;
         prescale <= '0;
         fadediv  <= '0;
      end else begin
         if (req) wb_dat_o <= rdata;
         if (wr) begin
            case (adr)
               ADDR_CTRL: if (wb_sel_i[0]) begin
                  enable <= wb_dat_i[CTRL_ENABLE_BIT];
                  invert <= wb_dat_i[CTRL_INVERT_BIT];
               end
               ADDR_PRESCALE: prescale <= PRE_BITS'(sel_merge(32'(prescale), wb_dat_i, wb_sel_i));
               ADDR_FADEDIV:  fadediv  <= 8'(sel_merge(32'(fadediv), wb_dat_i, wb_sel_i));
               default: ;
            endcase
         end
      end
   end

   // A PRESCALE below pre_cnt lets pre_cnt run through its natural wrap.
   always_comb begin
      tick       = enable && (pre_cnt == prescale);
      period_end = tick && (pwm_cnt == '1);
      raw        = cmp & {NCH{enable}};
   end

   always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
      if (wb_reset_i) begin
         pre_cnt <= '0;
         pwm_cnt <= '0;
         pwm_o   <= '0;
      end else begin
         if (!enable) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
         end else if (tick) begin
            pre_cnt <= '0;
            pwm_cnt <= pwm_cnt + 1'b1;
         end else begin
            pre_cnt <= pre_cnt + 1'b1;
         end
         pwm_o <= raw ^ {NCH{invert}};
      end
   end

   for (genvar n = 0; n < NCH; n++) begin : g_ch
      logic                wr_ch, fade_en, wr_fade_en;
      logic [PWM_BITS-1:0] target, live, wr_target;
      logic [31:0]         word;

      always_comb begin
         wr_ch      = wr && (adr == ADDR_CH0 + 4'(n));
         wr_target  = PWM_BITS'(sel_merge(word, wb_dat_i, wb_sel_i));
         wr_fade_en = wb_sel_i[FADE_EN_BIT/8] ? wb_dat_i[FADE_EN_BIT] : fade_en;
         word       = '0;
         word[PWM_BITS-1:0]          = target;
         word[FADE_EN_BIT]           = fade_en;
         word[LIVE_LSB +: LIVE_W]    = live[PWM_BITS-1 -: LIVE_W];
      end

      assign ch_word[n] = word;

      pwm_fade_channel #(.PWM_BITS(PWM_BITS)) u_ch (
         .clk        (wb_clk_i),
         .rst        (wb_reset_i),
         .wr         (wr_ch),
         .wr_target  (wr_target),
         .wr_fade_en (wr_fade_en),
         .pwm_cnt    (pwm_cnt),
         .period_end (period_end),
         .fadediv    (fadediv),
         .target     (target),
         .fade_en    (fade_en),
         .live       (live),
         .busy       (busy[n]),
         .cmp        (cmp[n])
      );
   end

endmodule

// File: tb/tb_wb_pwm_fader.sv
// Directed bench for wb_pwm_fader: register table, PWM duty windows,
// glitch-free update, fade ramps, invert/enable and reset behaviour.
module tb_wb_pwm_fader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [29:0] wb_adr_i = '0;
   logic [31:0] wb_dat_i = '0;
   logic [31:0] wb_dat_o;
   logic        wb_we_i = 1'b0;
   logic [3:0]  wb_sel_i = '0;
   logic        wb_cyc_i = 1'b0;
   logic        wb_stb_i = 1'b0;
   logic        wb_ack_o;
   logic [3:0]  pwm_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wb_pwm_fader #(.AW(30), .DW(32), .NCH(4), .PWM_BITS(8), .PRE_BITS(16)) dut (
      .wb_clk_i   (clk),
      .wb_reset_i (rst),
      .wb_adr_i   (wb_adr_i),
      .wb_dat_i   (wb_dat_i),
      .wb_dat_o   (wb_dat_o),
      .wb_we_i    (wb_we_i),
      .wb_sel_i   (wb_sel_i),
      .wb_cyc_i   (wb_cyc_i),
      .wb_stb_i   (wb_stb_i),
      .wb_ack_o   (wb_ack_o),
      .pwm_o      (pwm_o)
   );

   typedef struct {
      logic        we;
      logic [3:0]  adr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic bus(input logic we, input logic [3:0] adr, input logic [31:0] data,
                      input logic [3:0] sel, output logic [31:0] rd);
      bit got = 0;
      rd = '0;
      @(negedge clk);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
      wb_adr_i = '0;   wb_adr_i[3:0] = adr;
      wb_dat_i = data; wb_sel_i = sel;
      for (int i = 0; i < 4 && !got; i++) begin
         @(posedge clk); #1;
         if (wb_ack_o) begin
            got = 1;
            rd  = wb_dat_o;
         end
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      if (!got) begin
         n_checks++; n_fail++;
         $display("FAIL bus_ack: no ack for adr %h, expected ack within 4 cycles", adr);
      end
   endtask

   task automatic wr(input logic [3:0] adr, input logic [31:0] data);
      logic [31:0] dummy;
      bus(1'b1, adr, data, 4'hF, dummy);
   endtask

   task automatic rd(input logic [3:0] adr, output logic [31:0] data);
      bus(1'b0, adr, '0, 4'hF, data);
   endtask

   task automatic count_high(input int ch, input int n, output int hi);
      hi = 0;
      repeat (n) begin
         @(negedge clk);
         hi += int'(pwm_o[ch]);
      end
   endtask

   // Returns at the negedge where pwm_o[0] first shows high (counter at 0).
   task automatic wait_rise(input string name);
      logic prev;
      bit   found = 0;
      @(negedge clk);
      prev = pwm_o[0];
      for (int i = 0; i < 600 && !found; i++) begin
         @(negedge clk);
         if (!prev && pwm_o[0]) found = 1;
         prev = pwm_o[0];
      end
      if (!found) begin
         n_checks++; n_fail++;
         $display("FAIL %s: no period start seen, expected one within 600 cycles", name);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [3:0] adr, input logic [31:0] wdata,
                               input logic [3:0] sel, input logic [31:0] exp);
      vec_t v;
      v.we = we; v.adr = adr; v.wdata = wdata; v.sel = sel; v.exp = exp;
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time exceeded, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          hi0, hi1;
      logic [31:0] d;

      for (int a = 0; a < 8; a++) vecs.push_back(mk(0, 4'(a), '0, 4'hF, 32'h0));
      vecs.push_back(mk(1, 4'h0, 32'hFFFF_FFFF, 4'h0, 0));
      vecs.push_back(mk(0, 4'h0, 0, 4'hF, 32'h0));
      vecs.push_back(mk(1, 4'h1, 32'hABCD_EF12, 4'hF, 0));
      vecs.push_back(mk(0, 4'h1, 0, 4'hF, 32'h0000_EF12));
      vecs.push_back(mk(1, 4'h1, 32'h0000_0055, 4'h1, 0));
      vecs.push_back(mk(0, 4'h1, 0, 4'hF, 32'h0000_EF55));
      vecs.push_back(mk(1, 4'h1, 32'h0, 4'hF, 0));
      vecs.push_back(mk(0, 4'h1, 0, 4'hF, 32'h0));
      vecs.push_back(mk(1, 4'h2, 32'h0000_1234, 4'hF, 0));
      vecs.push_back(mk(0, 4'h2, 0, 4'hF, 32'h0000_0034));
      vecs.push_back(mk(1, 4'h2, 32'h0, 4'hF, 0));
      vecs.push_back(mk(1, 4'h3, 32'h0000_000F, 4'hF, 0));
      vecs.push_back(mk(0, 4'h3, 0, 4'hF, 32'h0));
      vecs.push_back(mk(1, 4'hF, 32'hFFFF_FFFF, 4'hF, 0));
      vecs.push_back(mk(0, 4'hF, 0, 4'hF, 32'h0));
      vecs.push_back(mk(1, 4'h7, 32'hFFFF_FFFF, 4'hF, 0));
      vecs.push_back(mk(0, 4'h7, 0, 4'hF, 32'h0001_00FF));
      vecs.push_back(mk(0, 4'h3, 0, 4'hF, 32'h0000_0008));
      vecs.push_back(mk(1, 4'h7, 32'h0, 4'hF, 0));
      vecs.push_back(mk(0, 4'h7, 0, 4'hF, 32'h0));
      vecs.push_back(mk(0, 4'h3, 0, 4'hF, 32'h0));
      vecs.push_back(mk(1, 4'h0, 32'hFFFF_FFFF, 4'h1, 0));
      vecs.push_back(mk(0, 4'h0, 0, 4'hF, 32'h0000_0003));
      vecs.push_back(mk(1, 4'h0, 32'h0, 4'hF, 0));
      vecs.push_back(mk(0, 4'h0, 0, 4'hF, 32'h0));
      vecs.push_back(mk(0, 4'h8, 0, 4'hF, 32'h0));

      // Power-on reset
      repeat (3) @(negedge clk);
      check("reset_pwm", 32'(pwm_o), 32'h0);
      check("reset_ack", 32'(wb_ack_o), 32'h0);
      check("reset_dat", wb_dat_o, 32'h0);
      rst = 1'b0;

      // Basic PWM; live duty stays 0 until the first period end
      wr(4'h1, 32'h0);
      wr(4'h4, 32'h40);
      wr(4'h5, 32'h30);
      wr(4'h0, 32'h1);
      count_high(0, 200, hi0);
      check("pre_first_period", 32'(hi0), 32'd0);
      repeat (100) @(negedge clk);
      fork
         count_high(0, 256, hi0);
         count_high(1, 256, hi1);
      join
      check("duty_40", 32'(hi0), 32'd64);
      check("duty_30", 32'(hi1), 32'd48);

      // Glitch-free: CH1 rewritten mid-period keeps old width this period
      wait_rise("glitch_sync");
      fork
         begin
            hi1 = int'(pwm_o[1]);
            repeat (255) begin
               @(negedge clk);
               hi1 += int'(pwm_o[1]);
            end
         end
         begin
            repeat (30) @(negedge clk);
            wr(4'h5, 32'h10);
         end
      join
      check("glitch_old_period", 32'(hi1), 32'd48);
      count_high(1, 256, hi1);
      check("glitch_new_period", 32'(hi1), 32'd16);

      // Duty extremes
      wr(4'h4, 32'hFF);
      wr(4'h5, 32'h00);
      repeat (300) @(negedge clk);
      fork
         count_high(0, 256, hi0);
         count_high(1, 256, hi1);
      join
      check("duty_ff", 32'(hi0), 32'd255);
      check("duty_00", 32'(hi1), 32'd0);
      wr(4'h4, 32'h40);

      // Fade up 0 -> 4 with FADEDIV=1: one step per two periods
      wr(4'h2, 32'h1);
      wait_rise("fade_sync");
      wr(4'h6, 32'h0001_0004);
      for (int p = 1; p <= 8; p++) begin
         wait_rise("fade_up_wait");
         rd(4'h6, d);
         check($sformatf("fade_up_live_p%0d", p), 32'(d[31:24]), 32'(p / 2));
         rd(4'h3, d);
         check($sformatf("fade_up_busy_p%0d", p), d, (p / 2 != 4) ? 32'h4 : 32'h0);
      end
      wr(4'h6, 32'h0001_0001);
      for (int p = 1; p <= 8; p++) begin
         wait_rise("fade_dn_wait");
         rd(4'h6, d);
         check($sformatf("fade_dn_live_p%0d", p), 32'(d[31:24]),
               (4 - p / 2 < 1) ? 32'd1 : 32'(4 - p / 2));
         rd(4'h3, d);
         check($sformatf("fade_dn_busy_p%0d", p), d, (4 - p / 2 > 1) ? 32'h4 : 32'h0);
      end

      // Invert
      wr(4'h0, 32'h3);
      repeat (300) @(negedge clk);
      count_high(0, 256, hi0);
      check("invert_duty_40", 32'(hi0), 32'd192);
      wr(4'h0, 32'h2);
      repeat (3) @(negedge clk);
      check("disabled_inverted", 32'(pwm_o), 32'hF);

      // Asynchronous reset mid-period with CH0 at 0x80
      wr(4'h0, 32'h1);
      wr(4'h4, 32'h80);
      repeat (300) @(negedge clk);
      count_high(0, 256, hi0);
      check("duty_80", 32'(hi0), 32'd128);
      repeat (50) @(negedge clk);
      #3 rst = 1'b1;
      #1;
      check("async_reset_pwm", 32'(pwm_o), 32'h0);
      check("async_reset_ack", 32'(wb_ack_o), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Register table, starting with reads of every register after reset
      foreach (vecs[i]) begin
         bus(vecs[i].we, vecs[i].adr, vecs[i].wdata, vecs[i].sel, d);
         if (!vecs[i].we) check($sformatf("vec%0d_adr%h", i, vecs[i].adr), d, vecs[i].exp);
      end

      // Held strobe: ack every other cycle
      repeat (3) @(negedge clk);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = '0;
      #1;
      check("held_ack_0", 32'(wb_ack_o), 32'h0);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("held_ack_%0d", k), 32'(wb_ack_o), 32'(k % 2));
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
